// File: rtl/shift_add_mul_ctrl.sv
// Sequencer and accumulator for a 4x4 shift-and-add multiplier built around an
// external 8-bit load/shift-left register (D/sel out, Q back in).
module shift_add_mul_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic [7:0] Q,
    output logic [3:0] D,
    output logic       sel,
    output logic [7:0] P,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {IDLE, LOAD, ACC, DONE} state_t;

    state_t     state, state_nxt;
    logic [3:0] a_reg, b_reg;
    logic [1:0] k;
    logic       accept;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // A new start is honoured only from IDLE or DONE; LOAD/ACC ignore it.
    always_comb begin
        state_nxt = state;
        sel       = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                sel       = 1'b1;
                busy      = 1'b1;
                state_nxt = ACC;
            end
            ACC: begin
                busy = 1'b1;
                if (k == 2'd3) state_nxt = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = LOAD;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Q holds a_reg<<k throughout ACC, so the partial product is added directly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_reg <= 4'd0;
            b_reg <= 4'd0;
            k     <= 2'd0;
            P     <= 8'd0;
        end else begin
            if (accept) begin
                a_reg <= A;
                b_reg <= B;
                P     <= 8'd0;
            end
            if (state == LOAD) k <= 2'd0;
            if (state == ACC) begin
                if (b_reg[k]) P <= P + Q;
                if (k != 2'd3) k <= k + 2'd1;
            end
        end
    end

    assign D = a_reg;

endmodule

// File: tb/tb_shift_add_mul_ctrl.sv
// Bench for shift_add_mul_ctrl: models the external shift register and checks
// products against plain A*B with a fixed five-cycle start-to-done latency.
module tb_shift_add_mul_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [3:0] A = 4'd0;
    logic [3:0] B = 4'd0;
    logic [7:0] Q;
    logic [3:0] D;
    logic       sel;
    logic [7:0] P;
    logic       busy;
    logic       done;

    int checks = 0;
    int failures = 0;

    shift_add_mul_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .A(A), .B(B), .Q(Q),
        .D(D), .sel(sel), .P(P), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // External 8-bit load / shift-left register sharing clk and reset.
    always @(posedge clk or posedge reset) begin
        if (reset)    Q <= 8'd0;
        else if (sel) Q <= {4'd0, D};
        else          Q <= {Q[6:0], 1'b0};
    end

    always @(negedge clk) begin
        if (!reset) begin
            checks++;
            if (busy && done) begin
                failures++;
                $display("FAIL busy_done_overlap busy=%0b done=%0b t=%0t", busy, done, $time);
            end
        end
    end

    task automatic run_op(input logic [3:0] a, input logic [3:0] b,
                          output int lat, output logic [7:0] p);
        A = a; B = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        A = 4'($urandom); B = 4'($urandom);
        lat = 99;
        p = P;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = i;
                p = P;
                break;
            end
        end
    endtask

    task automatic test_reset;
        logic [7:0] p_before;
        reset = 1'b0;
        @(posedge clk); #1;
        A = 4'd11; B = 4'd13; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        p_before = P;
        checks++;
        if (p_before !== 8'd11) begin
            failures++;
            $display("FAIL reset_pre_p got=%0d exp=11", p_before);
        end
        #2 reset = 1'b1;
        #1;
        checks++; if (D !== 4'd0)    begin failures++; $display("FAIL reset_d got=%0d exp=0", D); end
        checks++; if (sel !== 1'b0)  begin failures++; $display("FAIL reset_sel got=%0b exp=0", sel); end
        checks++; if (P !== 8'd0)    begin failures++; $display("FAIL reset_p got=%0d exp=0", P); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", done); end
        @(posedge clk); #3 reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        logic [7:0] exp_q [4] = '{8'd5, 8'd10, 8'd20, 8'd40};
        A = 4'd5; B = 4'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; A = 4'd0; B = 4'd0;
        checks++; if (sel !== 1'b1)  begin failures++; $display("FAIL basic_sel_load got=%0b exp=1", sel); end
        checks++; if (D !== 4'd5)    begin failures++; $display("FAIL basic_d got=%0d exp=5", D); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy got=%0b exp=1", busy); end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            checks++;
            if (Q !== exp_q[i] || sel !== 1'b0) begin
                failures++;
                $display("FAIL basic_q%0d got q=%0d sel=%0b exp q=%0d sel=0", i, Q, sel, exp_q[i]);
            end
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b1 || P !== 8'd15 || busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_done got done=%0b P=%0d busy=%0b exp 1/15/0", done, P, busy);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || P !== 8'd15) begin
            failures++;
            $display("FAIL basic_after got done=%0b P=%0d exp 0/15", done, P);
        end
    endtask

    task automatic test_extremes;
        logic [3:0] av [4] = '{4'd15, 4'd15, 4'd0, 4'd1};
        logic [3:0] bv [4] = '{4'd15, 4'd0, 4'd15, 4'd8};
        int lat;
        logic [7:0] p;
        for (int i = 0; i < 4; i++) begin
            run_op(av[i], bv[i], lat, p);
            checks++;
            if (lat != 5 || p !== 8'(av[i] * bv[i])) begin
                failures++;
                $display("FAIL extreme_%0dx%0d got lat=%0d P=%0d exp lat=5 P=%0d",
                         av[i], bv[i], lat, p, av[i] * bv[i]);
            end
            repeat (2) begin @(posedge clk); #1; end
            checks++;
            if (P !== 8'(av[i] * bv[i]) || done !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL extreme_hold got P=%0d done=%0b busy=%0b exp P=%0d", P, done, busy, av[i] * bv[i]);
            end
        end
    endtask

    task automatic test_start_handling;
        int lat;
        A = 4'd3; B = 4'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 99;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            start = (i == 2);
            if (i == 2) begin A = 4'd2; B = 4'd15; end
            if (done) begin lat = i; break; end
        end
        start = 1'b0;
        checks++;
        if (lat != 5 || P !== 8'd15) begin
            failures++;
            $display("FAIL start_ignored got lat=%0d P=%0d exp lat=5 P=15", lat, P);
        end
        A = 4'd7; B = 4'd9; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; A = 4'd1; B = 4'd1;
        checks++;
        if (P !== 8'd0 || busy !== 1'b1 || done !== 1'b0 || sel !== 1'b1) begin
            failures++;
            $display("FAIL start_in_done got P=%0d busy=%0b done=%0b sel=%0b exp 0/1/0/1", P, busy, done, sel);
        end
        lat = 99;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (done) begin lat = i; break; end
        end
        checks++;
        if (lat != 5 || P !== 8'd63) begin
            failures++;
            $display("FAIL start_in_done_result got lat=%0d P=%0d exp lat=5 P=63", lat, P);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid;
        int lat;
        logic [7:0] p;
        bit saw_done;
        A = 4'd9; B = 4'd15; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (P !== 8'd0 || busy !== 1'b0 || done !== 1'b0 || sel !== 1'b0) begin
            failures++;
            $display("FAIL resetmid_state got P=%0d busy=%0b done=%0b sel=%0b exp 0/0/0/0", P, busy, done, sel);
        end
        #3 reset = 1'b0;
        saw_done = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (done) saw_done = 1'b1;
        end
        checks++;
        if (saw_done || busy !== 1'b0) begin
            failures++;
            $display("FAIL resetmid_nodone got saw_done=%0b busy=%0b exp 0/0", saw_done, busy);
        end
        run_op(4'd6, 4'd7, lat, p);
        checks++;
        if (lat != 5 || p !== 8'd42) begin
            failures++;
            $display("FAIL resetmid_next got lat=%0d P=%0d exp lat=5 P=42", lat, p);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        logic [3:0] a, b;
        int lat;
        a = 4'($urandom); b = 4'($urandom);
        A = a; B = b; start = 1'b1;
        for (int op = 0; op < 4; op++) begin
            @(posedge clk); #1;
            A = 4'($urandom); B = 4'($urandom);
            lat = 99;
            for (int i = 1; i <= 20; i++) begin
                @(posedge clk); #1;
                A = 4'($urandom); B = 4'($urandom);
                if (done) begin lat = i; break; end
            end
            checks++;
            if (lat != 5 || P !== 8'(a * b)) begin
                failures++;
                $display("FAIL b2b_op%0d %0dx%0d got lat=%0d P=%0d exp lat=5 P=%0d", op, a, b, lat, P, a * b);
            end
            if (op < 3) begin
                a = 4'($urandom); b = 4'($urandom);
                A = a; B = b;
            end else begin
                start = 1'b0;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random;
        logic [3:0] a, b;
        int lat;
        logic [7:0] p;
        for (int n = 0; n < 200; n++) begin
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            a = 4'($urandom); b = 4'($urandom);
            run_op(a, b, lat, p);
            checks++;
            if (lat != 5 || p !== 8'(a * b)) begin
                failures++;
                $display("FAIL random_%0d %0dx%0d got lat=%0d P=%0d exp lat=5 P=%0d", n, a, b, lat, p, a * b);
            end
        end
    endtask

    initial begin
        #12;
        test_reset;
        test_basic;
        test_extremes;
        test_start_handling;
        test_reset_mid;
        test_back_to_back;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
